fp_addsub_seq: RTL and testbench

Multi-cycle sequencer for IEEE-754 single-precision add/subtract. Accepts one operand pair per transaction over a valid/ready handshake. Steps the shared exponent-compare, alignment, mantissa add and normalisation datapath through a fixed state machine, then holds the result until it is consumed. Sits between the operand issue logic and the FPU result writeback; rounding is truncation (round toward zero), and denormals are flushed to zero.

---
 rtl/fp_addsub_seq_pkg.sv | 24 ++
 rtl/mant_align_shift.sv | 16 +
 rtl/fp_addsub_seq.sv | 196 +++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_seq_pkg.sv
// Shared definitions for the sequential single-precision add/subtract unit:
// FSM state encodings, field widths and special-value constants.
package fp_addsub_seq_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = 24;

   localparam logic [31:0]      QNAN    = 32'h7FC00000;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAlign = 3'd1,
      StAdd   = 3'd2,
      StNorm  = 3'd3,
      StDone  = 3'd4
   } state_e;

   // Hidden bit restored; a zero exponent field flushes the operand to zero.
   function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] x);
      return (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
   endfunction

endpackage

// File: rtl/mant_align_shift.sv
// Combinational 24-bit right barrel shifter used to align the smaller mantissa.
// Shift amounts of 24 or more saturate the output to zero.
module mant_align_shift
   import fp_addsub_seq_pkg::*;
(
   input  logic [MANT_W-1:0] mant_i,
   input  logic [8:0]        shamt_i,
   output logic [MANT_W-1:0] mant_o
);

   always_comb begin
      if (shamt_i >= 9'(MANT_W)) mant_o = '0;
      else                       mant_o = mant_i >> shamt_i;
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract, truncating, denormals flushed.
// Define FPSEQ_SPECIAL_EN to bypass Inf/NaN operands straight to the result.
module fp_addsub_seq
   import fp_addsub_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        ovf,
   output logic        unf,
   output logic        busy
);

   state_e state_q, state_d;

   logic              sa_q, sa_d, sb_q, sb_d;
   logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
   logic [MANT_W-1:0] ma_q, ma_d, mb_q, mb_d;
   logic              sign_q, sign_d, sub_q, sub_d;
   logic [EXP_W:0]    exp_q, exp_d;
   logic [MANT_W-1:0] ml_q, ml_d, ms_q, ms_d;
   logic [31:0]       result_q, result_d;
   logic              ovf_q, ovf_d, unf_q, unf_d;

   logic              a_big;
   logic [8:0]        ediff, shamt;
   logic [MANT_W-1:0] aligned;
   logic [MANT_W:0]   sum;
   logic [MANT_W-1:0] norm_mant;
   logic [EXP_W:0]    exp_add;

   assign a_big   = (ea_q > eb_q) || ((ea_q == eb_q) && (ma_q >= mb_q));
   assign ediff   = {1'b0, ea_q} - {1'b0, eb_q};
   assign shamt   = ediff[8] ? (~ediff + 9'd1) : ediff;

   mant_align_shift u_align (
      .mant_i  (a_big ? mb_q : ma_q),
      .shamt_i (shamt),
      .mant_o  (aligned)
   );

   // ml_q is never smaller than ms_q, so the subtraction cannot go negative.
   assign sum       = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
   assign norm_mant = sum[MANT_W] ? sum[MANT_W:1] : sum[MANT_W-1:0];
   assign exp_add   = sum[MANT_W] ? exp_q + 9'd1 : exp_q;

`ifdef FPSEQ_SPECIAL_EN
   logic        special;
   logic [31:0] special_res;
   logic        nan_a, nan_b, inf_a, inf_b, eff_sb;

   always_comb begin
      eff_sb  = b[31] ^ op;
      inf_a   = (a[30:23] == EXP_MAX) && (a[22:0] == '0);
      inf_b   = (b[30:23] == EXP_MAX) && (b[22:0] == '0);
      nan_a   = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
      nan_b   = (b[30:23] == EXP_MAX) && (b[22:0] != '0);
      special = (a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX);
      if (nan_a || nan_b)                        special_res = QNAN;
      else if (inf_a && inf_b && (a[31] != eff_sb)) special_res = QNAN;
      else if (inf_a)                            special_res = {a[31], 8'hFF, 23'h0};
      else                                       special_res = {eff_sb, 8'hFF, 23'h0};
   end
`endif

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      ea_d     = ea_q;
      eb_d     = eb_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      sign_d   = sign_q;
      sub_d    = sub_q;
      exp_d    = exp_q;
      ml_d     = ml_q;
      ms_d     = ms_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sa_d    = a[31];
               ea_d    = a[30:23];
               ma_d    = unpack_mant(a);
               sb_d    = b[31] ^ op;
               eb_d    = b[30:23];
               mb_d    = unpack_mant(b);
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = StAlign;
`ifdef FPSEQ_SPECIAL_EN
               if (special) begin
                  result_d = special_res;
                  state_d  = StDone;
               end
`endif
            end
         end
         StAlign: begin
            sign_d  = a_big ? sa_q : sb_q;
            exp_d   = {1'b0, a_big ? ea_q : eb_q};
            ml_d    = a_big ? ma_q : mb_q;
            ms_d    = aligned;
            sub_d   = sa_q ^ sb_q;
            state_d = StAdd;
         end
         StAdd: begin
            if (exp_add >= {1'b0, EXP_MAX}) begin
               result_d = {sign_q, 8'hFF, 23'h0};
               ovf_d    = 1'b1;
               state_d  = StDone;
            end else if (norm_mant == '0) begin
               result_d = 32'h0;
               state_d  = StDone;
            end else begin
               ml_d    = norm_mant;
               exp_d   = exp_add;
               state_d = StNorm;
            end
         end
         StNorm: begin
            if (ml_q[MANT_W-1]) begin
               result_d = {sign_q, exp_q[EXP_W-1:0], ml_q[MANT_W-2:0]};
               state_d  = StDone;
            end else begin
               ml_d  = {ml_q[MANT_W-2:0], 1'b0};
               exp_d = exp_q - 9'd1;
               if (exp_q == 9'd1) begin
                  result_d = 32'h0;
                  unf_d    = 1'b1;
                  state_d  = StDone;
               end
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         exp_q    <= '0;
         ml_q     <= '0;
         ms_q     <= '0;
         result_q <= 32'h0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         sign_q   <= sign_d;
         sub_q    <= sub_d;
         exp_q    <= exp_d;
         ml_q     <= ml_d;
         ms_q     <= ms_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed vectors, an arithmetic reference
// model checked every cycle, backpressure and mid-operation reset.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        ovf, unf, busy;

   int n_checks = 0;
   int n_fail   = 0;

   fp_addsub_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .unf       (unf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Reference: exact integer arithmetic on unpacked fields, truncating alignment,
   // normalise by counting leading shifts; lat = cycles from transfer edge to DONE.
   function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic o,
                                 output logic [31:0] r, output logic fo, output logic fu,
                                 output int lat);
      int     ex, ey, el, es, e, k;
      longint mx, my, ml, ms, s;
      logic   sx, sy, sl;
      fo = 1'b0;
      fu = 1'b0;
      sx = x[31];
      sy = y[31] ^ o;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
`ifdef FPSEQ_SPECIAL_EN
      if (ex == 255 || ey == 255) begin
         lat = 1;
         if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) r = 32'h7FC00000;
         else if (ex == 255 && ey == 255 && sx != sy)                   r = 32'h7FC00000;
         else if (ex == 255)                                              r = {sx, 8'hFF, 23'h0};
         else                                                             r = {sy, 8'hFF, 23'h0};
         return;
      end
`endif
      mx = (ex == 0) ? 64'd0 : (longint'(x[22:0]) + 64'd8388608);
      my = (ey == 0) ? 64'd0 : (longint'(y[22:0]) + 64'd8388608);
      if (ex > ey || (ex == ey && mx >= my)) begin
         sl = sx; el = ex; ml = mx; es = ey; ms = my;
      end else begin
         sl = sy; el = ey; ml = my; es = ex; ms = mx;
      end
      if (el - es >= 24) ms = 0;
      else               ms = ms >> (el - es);
      s = (sx != sy) ? ml - ms : ml + ms;
      e = el;
      if (s >= 64'd16777216) begin
         s = s / 2;
         e = e + 1;
      end
      if (e >= 255) begin
         r = {sl, 8'hFF, 23'h0}; fo = 1'b1; lat = 3;
         return;
      end
      if (s == 0) begin
         r = 32'h0; lat = 3;
         return;
      end
      k = 0;
      while (s < 64'd8388608) begin
         s = s * 2;
         e = e - 1;
         k = k + 1;
         if (e == 0) begin
            r = 32'h0; fu = 1'b1; lat = 3 + k;
            return;
         end
      end
      r   = {sl, e[7:0], s[22:0]};
      lat = 4 + k;
   endfunction

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        vop;
      logic [31:0] r;
      logic        fo;
      logic        fu;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[$];

   // Per-cycle checker against the model, tracking one in-flight transaction.
   int          ncyc = 0, done_cyc = 0, m_lat;
   bit          active = 0, started = 0;
   logic [31:0] m_r;
   logic        m_o, m_u;

   initial begin
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst) begin
            started = 1;
            active  = 0;
         end else if (started) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !active});
            chk("busy", {31'b0, busy}, {31'b0, active});
            chk("out_valid", {31'b0, out_valid}, {31'b0, active && ncyc >= done_cyc});
            if (active && ncyc >= done_cyc) begin
               chk("cyc_result", result, m_r);
               chk("cyc_ovf", {31'b0, ovf}, {31'b0, m_o});
               chk("cyc_unf", {31'b0, unf}, {31'b0, m_u});
               if (out_ready) active = 0;
            end else if (!active && in_valid) begin
               model(a, b, op, m_r, m_o, m_u, m_lat);
               active   = 1;
               done_cyc = ncyc + m_lat;
            end
         end
      end
   end

   task automatic send(input vec_t v);
      int          n;
      logic [31:0] held;
      in_valid = 1'b1;
      a  = v.va;
      b  = v.vb;
      op = v.vop;
      n  = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 60) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", 32'(n), 32'(v.lat));
      chk("result", result, v.r);
      chk("ovf", {31'b0, ovf}, {31'b0, v.fo});
      chk("unf", {31'b0, unf}, {31'b0, v.fu});
      held = result;
      repeat (v.hold) begin
         @(posedge clk); #1;
      end
      if (v.hold > 0) begin
         chk("held_result", result, held);
         chk("held_in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] pr;
      logic        po, pu;
      int          pl, n;

      vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 0});
      vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 3, 0});
      vecs.push_back('{32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 5, 5});
      vecs.push_back('{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0, 4, 0});
      vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3, 2});
      vecs.push_back('{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 0});
      vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 3, 0});
      vecs.push_back('{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4, 0});
      vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h00000000, 1'b0, 1'b1, 4, 0});
      vecs.push_back('{32'hC0000000, 32'hBF800000, 1'b0, 32'hC0400000, 1'b0, 1'b0, 4, 0});
      vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 5, 1});
`ifdef FPSEQ_SPECIAL_EN
      vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 1, 0});
      vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1, 0});
      vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1, 0});
`endif

      // Pin the reference model to the hand-computed table.
      foreach (vecs[i]) begin
         model(vecs[i].va, vecs[i].vb, vecs[i].vop, pr, po, pu, pl);
         chk("model_result", pr, vecs[i].r);
         chk("model_flags", {30'b0, po, pu}, {30'b0, vecs[i].fo, vecs[i].fu});
         chk("model_latency", 32'(pl), 32'(vecs[i].lat));
      end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset_result", result, 32'h0);
      chk("reset_out_valid", {29'b0, out_valid, ovf, unf}, 32'd0);

      foreach (vecs[i]) send(vecs[i]);

      // Reset while the transaction sits in ALIGN.
      in_valid = 1'b1;
      a  = 32'h3F800000;
      b  = 32'h3F800000;
      op = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("align_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
      for (n = 0; n < 6; n++) begin
         chk("post_reset_no_valid", {31'b0, out_valid}, 32'd0);
         @(posedge clk); #1;
      end

      send(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
